// File: rtl/sap1_pkg.sv
// Shared SAP-1 control definitions: opcodes, one-hot T-states and the
// bit positions of the twelve control strobes inside a control word.
package sap1_pkg;

  localparam logic [3:0] OP_LDA = 4'h0;
  localparam logic [3:0] OP_ADD = 4'h1;
  localparam logic [3:0] OP_SUB = 4'h2;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  typedef enum logic [5:0] {
    T1 = 6'b000001,
    T2 = 6'b000010,
    T3 = 6'b000100,
    T4 = 6'b001000,
    T5 = 6'b010000,
    T6 = 6'b100000
  } t_state_e;

  localparam int NUM_CTRL   = 12;
  localparam int CW_PC_INC  = 0;
  localparam int CW_PC_EN   = 1;
  localparam int CW_MAR_LD  = 2;
  localparam int CW_RAM_EN  = 3;
  localparam int CW_IR_LD   = 4;
  localparam int CW_IR_EN   = 5;
  localparam int CW_A_LD    = 6;
  localparam int CW_A_EN    = 7;
  localparam int CW_B_LD    = 8;
  localparam int CW_ALU_EN  = 9;
  localparam int CW_ALU_SUB = 10;
  localparam int CW_OUT_LD  = 11;

  typedef logic [NUM_CTRL-1:0] ctrl_word_t;

endpackage

// File: rtl/ring_counter.sv
// Six-state one-hot ring T1..T6; reset forces T1, hold freezes the ring.
module ring_counter
  import sap1_pkg::*;
(
  input  logic     clk,
  input  logic     reset,
  input  logic     hold,
  output t_state_e t_state
);

  t_state_e t_state_q;
  t_state_e t_state_d;

  always_comb begin
    // NOTE: default assignment first so every path drives t_state_d and no latch is inferred.
    t_state_d = t_state_q;
    if (!hold) begin
      case (t_state_q)
        T1:      t_state_d = T2;
        T2:      t_state_d = T3;
        T3:      t_state_d = T4;
        T4:      t_state_d = T5;
        T5:      t_state_d = T6;
        T6:      t_state_d = T1;
        default: t_state_d = T1;
      endcase
    end
  end

  // NOTE: non-blocking assignment for flops so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) t_state_q <= T1;
    else       t_state_q <= t_state_d;
  end

  assign t_state = t_state_q;

endmodule

// File: rtl/controller_sequencer.sv
// SAP-1 controller/sequencer: ring counter, halt flag and the per-T-state
// opcode decode that produces every register load/enable strobe.
module controller_sequencer
  import sap1_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] instruction,
  output logic [5:0] t_state,
  output logic       pc_increment,
  output logic       pc_enable,
  output logic       mar_load,
  output logic       ram_enable,
  output logic       ir_load,
  output logic       ir_enable,
  output logic       a_load,
  output logic       a_enable,
  output logic       b_load,
  output logic       alu_enable,
  output logic       alu_subtract,
  output logic       out_load,
  output logic       halt
);

  t_state_e   ring_state;
  logic       hlt_now;
  logic       halt_q;
  logic       halt_d;
  ctrl_word_t ctrl;
  ctrl_word_t ctrl_gated;

  // HLT in T4 must freeze the ring on the same edge that sets the flag.
  assign hlt_now = (ring_state == T4) && (instruction == OP_HLT);

  ring_counter u_ring (
    .clk     (clk),
    .reset   (reset),
    .hold    (halt_q | hlt_now),
    .t_state (ring_state)
  );

  always_comb begin
    halt_d = halt_q;
    if (hlt_now) halt_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (reset) halt_q <= 1'b0;
    else       halt_q <= halt_d;
  end

  always_comb begin
    ctrl = '0;
    case (ring_state)
      T1: begin
        ctrl[CW_PC_EN]  = 1'b1;
        ctrl[CW_MAR_LD] = 1'b1;
      end
      T2: ctrl[CW_PC_INC] = 1'b1;
      T3: begin
        ctrl[CW_RAM_EN] = 1'b1;
        ctrl[CW_IR_LD]  = 1'b1;
      end
      T4: begin
        case (instruction)
          OP_LDA, OP_ADD, OP_SUB: begin
            ctrl[CW_IR_EN]  = 1'b1;
            ctrl[CW_MAR_LD] = 1'b1;
          end
          OP_OUT: begin
            ctrl[CW_A_EN]   = 1'b1;
            ctrl[CW_OUT_LD] = 1'b1;
          end
          default: ;
        endcase
      end
      T5: begin
        case (instruction)
          OP_LDA: begin
            ctrl[CW_RAM_EN] = 1'b1;
            ctrl[CW_A_LD]   = 1'b1;
          end
          OP_ADD, OP_SUB: begin
            ctrl[CW_RAM_EN]  = 1'b1;
            ctrl[CW_B_LD]    = 1'b1;
            ctrl[CW_ALU_SUB] = (instruction == OP_SUB);
          end
          default: ;
        endcase
      end
      T6: begin
        if (instruction == OP_ADD || instruction == OP_SUB) begin
          ctrl[CW_ALU_EN]  = 1'b1;
          ctrl[CW_A_LD]    = 1'b1;
          ctrl[CW_ALU_SUB] = (instruction == OP_SUB);
        end
      end
      default: ;
    endcase
  end

  assign ctrl_gated = (reset || halt_q) ? '0 : ctrl;

  assign t_state      = ring_state;
  assign halt         = halt_q;
  assign pc_increment = ctrl_gated[CW_PC_INC];
  assign pc_enable    = ctrl_gated[CW_PC_EN];
  assign mar_load     = ctrl_gated[CW_MAR_LD];
  assign ram_enable   = ctrl_gated[CW_RAM_EN];
  assign ir_load      = ctrl_gated[CW_IR_LD];
  assign ir_enable    = ctrl_gated[CW_IR_EN];
  assign a_load       = ctrl_gated[CW_A_LD];
  assign a_enable     = ctrl_gated[CW_A_EN];
  assign b_load       = ctrl_gated[CW_B_LD];
  assign alu_enable   = ctrl_gated[CW_ALU_EN];
  assign alu_subtract = ctrl_gated[CW_ALU_SUB];
  assign out_load     = ctrl_gated[CW_OUT_LD];

endmodule
